// File: rtl/fpu_pkg.sv
// Shared constants, FSM state encoding and IEEE-754 packing helpers for the
// single-precision normalise-and-round stage.
package fpu_pkg;

  localparam int XLEN    = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] pack_fp(input logic sign, input logic [7:0] exp,
                                          input logic [22:0] frac);
    return {sign, exp, frac};
  endfunction

  function automatic logic [31:0] pack_inf(input logic sign);
    return {sign, 8'hFF, 23'd0};
  endfunction

  function automatic logic [31:0] pack_zero(input logic sign);
    return {sign, 8'h00, 23'd0};
  endfunction

endpackage

// File: rtl/fp_rne_round.sv
// Round-to-nearest-even on a normalised 24-bit significand. The exponent is
// one bit wider than the stored field so a carry into 255 is seen, not wrapped.
module fp_rne_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [MAN_W:0]   m,
  input  logic [EXP_W:0]   exp,
  input  logic             g,
  input  logic             r,
  input  logic             s,
  output logic [MAN_W-1:0] frac,
  output logic [EXP_W-1:0] exp_out,
  output logic             overflow,
  output logic             inexact
);

  logic           inc;
  logic [MAN_W:0] frac_sum;
  logic           carry;
  logic [EXP_W:0] exp_rnd;

  // Increment on guard unless an exact tie would leave an even LSB; a carry
  // out of the hidden bit leaves fraction zero and bumps the exponent.
  always_comb begin
    inc      = g & (r | s | m[0]);
    frac_sum = {1'b0, m[MAN_W-1:0]} + {{MAN_W{1'b0}}, inc};
    carry    = m[MAN_W] & frac_sum[MAN_W];
    exp_rnd  = exp + {{EXP_W{1'b0}}, carry};
    frac     = frac_sum[MAN_W-1:0];
    exp_out  = exp_rnd[EXP_W-1:0];
    overflow = exp_rnd >= {1'b0, {EXP_W{1'b1}}};
    inexact  = g | r | s | overflow;
  end

endmodule

// File: rtl/fp_norm_round.sv
// Sequential normalise-and-round stage: takes the raw adder sum, shifts it one
// bit per cycle into normalised form, rounds to nearest-even and holds the
// packed result with flags until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a raw sum, in_ready high
// NORM  | one right or left shift per cycle, or flush to zero on underflow
// ROUND | round the normalised significand and load result/flags
// DONE  | out_valid high, result held until out_ready
module fp_norm_round #(
  parameter int XLEN  = 32,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [MAN_W+1:0] in_mant,
  input  logic [2:0]       in_grs,
  input  logic             in_nan,
  input  logic             in_inf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  result,
  output logic             overflow,
  output logic             underflow,
  output logic             exception,
  output logic             inexact
);
  import fpu_pkg::*;

  localparam logic [EXP_W:0] EXP_ONE = 1;

  state_t           state, state_nxt;
  logic             sign_q;
  logic [EXP_W:0]   exp_q;
  logic [MAN_W+1:0] m_q;
  logic             g_q, r_q, s_q;

  logic             in_zero, in_special, in_needs_norm;
  logic             do_right, do_left, do_flush;
  logic [MAN_W-1:0] rnd_frac;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_ovf, rnd_inexact;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);

  fp_rne_round #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
    .m        (m_q[MAN_W:0]),
    .exp      (exp_q),
    .g        (g_q),
    .r        (r_q),
    .s        (s_q),
    .frac     (rnd_frac),
    .exp_out  (rnd_exp),
    .overflow (rnd_ovf),
    .inexact  (rnd_inexact)
  );

  // Classify the incoming sum and choose this cycle's normalisation action.
  always_comb begin
    in_zero       = (in_mant == '0) && (in_grs == 3'b000);
    in_special    = in_nan || in_inf || in_zero;
    in_needs_norm = in_mant[MAN_W+1] || (!in_mant[MAN_W] && (in_exp != '0));
    do_right      = m_q[MAN_W+1];
    do_left       = !m_q[MAN_W+1] && !m_q[MAN_W] && (exp_q > EXP_ONE);
    do_flush      = !m_q[MAN_W+1] && !m_q[MAN_W] && (exp_q == EXP_ONE);
  end

  // Next state; NORM looks at the post-shift value so a shift that lands
  // normalised goes straight to ROUND without an extra check cycle.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (in_special)         state_nxt = DONE;
          else if (in_needs_norm) state_nxt = NORM;
          else                    state_nxt = ROUND;
        end
      end
      NORM: begin
        if (do_right)      state_nxt = ROUND;
        else if (do_left)  state_nxt = m_q[MAN_W-1] ? ROUND : NORM;
        else if (do_flush) state_nxt = DONE;
        else               state_nxt = ROUND;
      end
      ROUND:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch, shift datapath, and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q    <= 1'b0;
      exp_q     <= '0;
      m_q       <= '0;
      g_q       <= 1'b0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      exception <= 1'b0;
      inexact   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q <= in_sign;
            exp_q  <= {1'b0, in_exp};
            m_q    <= in_mant;
            g_q    <= in_grs[2];
            r_q    <= in_grs[1];
            s_q    <= in_grs[0];
            if (in_special) begin
              overflow  <= 1'b0;
              underflow <= 1'b0;
              inexact   <= 1'b0;
              if (in_nan) begin
                result    <= QNAN;
                exception <= 1'b1;
              end else if (in_inf) begin
                result    <= pack_inf(in_sign);
                exception <= 1'b1;
              end else begin
                result    <= pack_zero(in_sign);
                exception <= 1'b0;
              end
            end
          end
        end
        NORM: begin
          if (do_right) begin
            m_q   <= m_q >> 1;
            g_q   <= m_q[0];
            r_q   <= g_q;
            s_q   <= r_q | s_q;
            exp_q <= exp_q + EXP_ONE;
          end else if (do_left) begin
            m_q   <= {m_q[MAN_W:0], g_q};
            g_q   <= r_q;
            r_q   <= 1'b0;
            exp_q <= exp_q - EXP_ONE;
          end else if (do_flush) begin
            result    <= pack_zero(sign_q);
            overflow  <= 1'b0;
            underflow <= 1'b1;
            exception <= 1'b0;
            inexact   <= 1'b1;
          end
        end
        ROUND: begin
          result    <= rnd_ovf ? pack_inf(sign_q) : pack_fp(sign_q, rnd_exp, rnd_frac);
          overflow  <= rnd_ovf;
          underflow <= 1'b0;
          exception <= 1'b0;
          inexact   <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

endmodule
